// File: rtl/mem_sys_pkg.sv
// Shared types and defaults for the cached memory subsystem: FSM states,
// default widths, cache line layout and the main-memory power-up pattern.
package mem_sys_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int INDEX_W_DEF = 4;
  localparam int MEM_LAT_DEF = 4;
  localparam int TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF;

  localparam logic [31:0] MEM_INIT_BASE = 32'hC0DE0000;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } line_t;

  // Power-up content of main memory word a.
  function automatic logic [31:0] mem_init_word(input logic [31:0] a);
    return MEM_INIT_BASE | a;
  endfunction

endpackage

// File: rtl/memory_system_main_memory.sv
// Fixed-latency main memory: a one-cycle req starts an access that completes
// MEM_LAT cycles later with a done pulse (and rdata for reads).
module main_memory_model
  import mem_sys_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  localparam int WORDS = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  // Stored as a delta against the power-up pattern, so an all-zero array
  // reads back as the required initial contents.
  logic [DATA_W-1:0] store_mem [WORDS] = '{default: '0};

  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q;

  logic              fire;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] op_pat;

  always_comb begin
    busy_d   = busy_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    fire     = 1'b0;
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (!rst) begin
      if (req) begin
        busy_d  = 1'b1;
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        cnt_d   = CNT_W'(MEM_LAT - 1);
        if (MEM_LAT == 1) begin
          fire     = 1'b1;
          busy_d   = 1'b0;
          op_we    = we;
          op_addr  = addr;
          op_wdata = wdata;
        end
      end else if (busy_q) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          fire   = 1'b1;
          busy_d = 1'b0;
        end
      end
    end
    done_d = fire;
    op_pat = DATA_W'(mem_init_word(32'(op_addr)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Array access only on the completing cycle, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (fire && op_we) store_mem[op_addr] <= op_wdata ^ op_pat;
    if (fire && !op_we) rdata_q <= store_mem[op_addr] ^ op_pat;
  end

  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/memory_system_top.sv
// Direct-mapped write-back / write-allocate cache with its control FSM,
// in front of the fixed-latency main memory model.
module memory_system_top
  import mem_sys_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata
);

  localparam int LINES = 1 << INDEX_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit_q, hit_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  line_t line_q [LINES];
  line_t line_d [LINES];
  line_t cur_line;
  line_t line_wr;
  logic  line_we;

  logic [INDEX_W-1:0]        idx;
  logic [ADDR_W-INDEX_W-1:0] tag;
  logic                      lookup_hit;

  logic              mem_req, mem_we, mem_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  assign idx        = addr_q[INDEX_W-1:0];
  assign tag        = addr_q[ADDR_W-1:INDEX_W];
  assign cur_line   = line_q[idx];
  assign lookup_hit = cur_line.valid && (cur_line.tag == tag);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hit_d     = hit_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    line_we   = 1'b0;
    line_wr   = cur_line;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = cur_line.data;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        if (lookup_hit) begin
          if (we_q) begin
            line_we       = 1'b1;
            line_wr.dirty = 1'b1;
            line_wr.data  = wdata_q;
            rdata_d       = wdata_q;
          end else begin
            rdata_d = cur_line.data;
          end
          ready_d = 1'b1;
          state_d = RESPOND;
        end else if (cur_line.valid && cur_line.dirty) begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {cur_line.tag, idx};
          state_d  = WRITEBACK;
        end else begin
          mem_req = 1'b1;
          state_d = REFILL;
        end
      end
      WRITEBACK: begin
        // Victim is safely in memory; chain straight into the refill read.
        if (mem_done) begin
          mem_req = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_done) begin
          line_we       = 1'b1;
          line_wr.valid = 1'b1;
          line_wr.dirty = we_q;
          line_wr.tag   = tag;
          line_wr.data  = we_q ? wdata_q : mem_rdata;
          rdata_d       = line_wr.data;
          ready_d       = 1'b1;
          state_d       = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      assign line_d[gi] = (line_we && idx == INDEX_W'(gi)) ? line_wr : line_q[gi];
      always_ff @(posedge clk) begin
        if (rst) line_q[gi] <= '0;
        else     line_q[gi] <= line_d[gi];
      end
    end
  endgenerate

  main_memory_model #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .req  (mem_req),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .done (mem_done),
    .rdata(mem_rdata)
  );

  assign cpu_ready = ready_q;
  assign cpu_hit   = hit_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_memory_system_top.sv
// Bench for memory_system_top: directed scenarios plus random traffic checked
// against an array-level cache/memory reference model.
module tb_memory_system_top;

  localparam int MEM_LAT = 4;
  localparam int BOUND   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_hit;

  always #5 clk = ~clk;

  memory_system_top #(
    .ADDR_W(16), .DATA_W(32), .INDEX_W(4), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: sparse main memory plus per-index valid/dirty/tag/data.
  logic [31:0] ref_mem [int];
  bit          c_valid [16];
  bit          c_dirty [16];
  logic [11:0] c_tag   [16];
  logic [31:0] c_data  [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 32'hC0DE0000 | {16'h0, a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      c_valid[i] = 1'b0;
      c_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                              output int lat, output logic hit, output logic [31:0] rd);
    int          i;
    logic [11:0] tg;
    i   = int'(a[3:0]);
    tg  = a[15:4];
    hit = c_valid[i] && (c_tag[i] == tg);
    if (hit) begin
      lat = 2;
    end else begin
      if (c_valid[i] && c_dirty[i]) begin
        ref_mem[int'({c_tag[i], a[3:0]})] = c_data[i];
        lat = 2 + 2 * MEM_LAT;
      end else begin
        lat = 2 + MEM_LAT;
      end
      c_valid[i] = 1'b1;
      c_dirty[i] = 1'b0;
      c_tag[i]   = tg;
      c_data[i]  = ref_read(a);
    end
    if (we) begin
      c_data[i]  = wd;
      c_dirty[i] = 1'b1;
      rd         = wd;
    end else begin
      rd = c_data[i];
    end
  endtask

  // Counts edges from the sampling edge (edge 1) until cpu_ready is seen.
  task automatic wait_ready(input bit stray, output int n);
    n = 1;
    while (n < BOUND) begin
      @(posedge clk); #1;
      n++;
      if (stray && n == 3) begin
        cpu_req  = 1'b1;
        cpu_addr = cpu_addr ^ 16'h0100;
        cpu_we   = ~cpu_we;
      end
      if (stray && n == 4) cpu_req = 1'b0;
      if (cpu_ready) break;
    end
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (cpu_ready) pulses++;
    end
    check_eq({tag, "_extra_ready"}, 32'(pulses), 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] wd,
                        input bit stray, input string tag);
    int          lat, n;
    logic        hit;
    logic [31:0] rd;
    model_access(we, a, wd, lat, hit, rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_ready(stray, n);
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_hit"}, {31'b0, cpu_hit}, {31'b0, hit});
    check_eq({tag, "_rdata"}, cpu_rdata, rd);
    quiet_window(tag, stray ? 3 * MEM_LAT + 4 : 1);
  endtask

  // cpu_req stays high through the first completion; the second read must be
  // taken on the first IDLE edge after RESPOND.
  task automatic do_held(input logic [15:0] a1, input logic [15:0] a2);
    int          lat1, lat2, n;
    logic        h1, h2;
    logic [31:0] r1, r2;
    model_access(1'b0, a1, 32'h0, lat1, h1, r1);
    model_access(1'b0, a2, 32'h0, lat2, h2, r2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a1;
    @(posedge clk); #1;
    wait_ready(1'b0, n);
    check_eq("held1_lat", 32'(n), 32'(lat1));
    check_eq("held1_rdata", cpu_rdata, r1);
    cpu_addr = a2;
    n = 0;
    while (n < BOUND) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) cpu_req = 1'b0;
      if (cpu_ready) break;
    end
    check_eq("held2_lat", 32'(n), 32'(1 + lat2));
    check_eq("held2_hit", {31'b0, cpu_hit}, {31'b0, h2});
    check_eq("held2_rdata", cpu_rdata, r2);
    cpu_req = 1'b0;
    quiet_window("held2", 1);
  endtask

  // Starts a read, pulls rst after edge rst_at, and expects no completion.
  task automatic abort_req(input logic [15:0] a, input int rst_at, input string tag);
    int seen, n;
    seen = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 1;
    while (n < rst_at) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ready) seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq({tag, "_rst_hit"}, {31'b0, cpu_hit}, 32'd0);
    check_eq({tag, "_rst_rdata"}, cpu_rdata, 32'd0);
    repeat (3 * MEM_LAT + 6) begin
      @(posedge clk); #1;
      if (cpu_ready) seen++;
    end
    check_eq({tag, "_ready_pulses"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", {31'b0, cpu_ready}, 32'd0);
    check_eq("reset_hit", {31'b0, cpu_hit}, 32'd0);
    check_eq("reset_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 16'h0010, 32'h0, 1'b0, "rd_cold");
    do_req(1'b1, 16'h0010, 32'h12345678, 1'b0, "wr_hit");
    do_req(1'b0, 16'h0010, 32'h0, 1'b0, "rd_hit");
    do_req(1'b0, 16'h0100, 32'h0, 1'b0, "rd_dirty_miss");
    do_req(1'b0, 16'h0010, 32'h0, 1'b0, "rd_wb_back");
    do_req(1'b0, 16'h0230, 32'h0, 1'b1, "stray_req");
    do_req(1'b0, 16'h0045, 32'h0, 1'b0, "raw_rd");
    do_req(1'b1, 16'h0045, 32'hA5A5_0F0F, 1'b0, "raw_wr");
    do_req(1'b0, 16'h0045, 32'h0, 1'b0, "raw_rd2");
    do_held(16'h0045, 16'h0077);

    // Abort during writeback: the victim must never reach memory.
    do_req(1'b1, 16'h0032, 32'hDEADBEEF, 1'b0, "dirty_setup");
    abort_req(16'h0132, 4, "abort_wb");
    do_req(1'b0, 16'h0032, 32'h0, 1'b0, "after_wb_abort");

    abort_req(16'h0055, 4, "abort_refill");
    do_req(1'b0, 16'h0055, 32'h0, 1'b0, "after_refill_abort");

    for (int t = 0; t < 150; t++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      do_req(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 7) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_system_top.md
Name: memory_system_top

Overview:
- CPU-side memory subsystem: a direct-mapped, write-back, write-allocate cache in front of a behavioural main memory with fixed latency.
- Services single-word read/write requests from a CPU through a pulse-request / pulse-ready handshake.
- Top of the memory hierarchy under test.
- The CPU sees only the cache port; main memory is internal.

Parameters:
- ADDR_W, 16: word address width; main memory holds 2^ADDR_W words.
- DATA_W, 32: data word width.
- INDEX_W, 4: cache index width, giving 2^INDEX_W lines of one word each.
- MEM_LAT, 4: main-memory access latency in clock cycles, for each read or write.

Ports:
- clk  in  1  single system clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  word address; sampled with cpu_req.
- cpu_wdata  in  DATA_W  write data; sampled with cpu_req.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  1 if the completed access hit in the cache; valid while cpu_ready=1.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1 and held until the next completion.

Behaviour:
- Address split:
  - index = cpu_addr[INDEX_W-1:0].
  - tag = cpu_addr[ADDR_W-1:INDEX_W].
- Per line: valid, dirty, tag, data.
- Reset:
  - All valid and dirty bits cleared.
  - FSM goes to IDLE.
  - cpu_ready=0, cpu_hit=0, cpu_rdata=0.
  - Main-memory contents are NOT affected by rst.
- Main memory initial content at time zero: mem[a] = 32'hC0DE0000 | a, zero-extended.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: on a clk edge with cpu_req=1, latch addr/we/wdata and go to LOOKUP. Requests arriving in any other state are ignored (not queued).
- LOOKUP (1 cycle): hit = valid and tag match.
  - Hit read: latch data into the response and go to RESPOND.
  - Hit write: write data, set dirty, go to RESPOND.
  - Miss with a valid, dirty victim: go to WRITEBACK.
  - Miss otherwise: go to REFILL.
  - Record hit/miss for cpu_hit.
- WRITEBACK: write the victim data to mem[{victim_tag, index}]; takes MEM_LAT cycles, then go to REFILL.
- REFILL: read mem[latched addr] over MEM_LAT cycles. Then:
  - Install the line: valid=1, dirty=0, new tag.
  - On a write, merge cpu_wdata into the line and set dirty=1.
  - On a read, the response data is the refilled word.
  - Go to RESPOND.
- RESPOND (1 cycle):
  - cpu_ready=1 for exactly this cycle.
  - cpu_hit reflects the LOOKUP result.
  - cpu_rdata = read data; for writes, cpu_rdata = written data.
  - Return to IDLE.
- Latency, counted from the sampling edge to cpu_ready rising:
  - Hit: 2 edges.
  - Clean miss: 2+MEM_LAT.
  - Dirty miss: 2+2*MEM_LAT.
- cpu_req held high across completion: a new request is accepted at the first IDLE edge after RESPOND.
- Same-address write after read in back-to-back requests: must see the updated line; no stale read.
- rst asserted mid-transaction:
  - Aborts immediately to IDLE with no memory write completed.
  - Cache state is invalidated (dirty data lost, by design).
- cpu_hit and cpu_rdata are registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package mem_sys_pkg:
  - State enum (IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND).
  - Default widths.
  - MEM_INIT_BASE = 32'hC0DE0000.
  - Cache line struct {valid, dirty, tag, data}.
- One natural sub-module: main_memory_model.
  - Array of 2^ADDR_W words.
  - req/we/addr/wdata in; done pulse and rdata out after MEM_LAT cycles.
- Cache arrays and the FSM live in the top.

Test Plan:
- Reset, then read 0x0010 -> cpu_ready after 2+MEM_LAT edges; cpu_hit=0; cpu_rdata=32'hC0DE0010.
- Write 0x0010 with 32'h12345678 -> cpu_ready after 2 edges; cpu_hit=1; line 0 becomes dirty.
- Read 0x0010 -> cpu_hit=1; cpu_rdata=32'h12345678; latency 2 edges.
- Read 0x0100 (same index 0, tag 0x010) -> cpu_hit=0; writeback latency included (2+2*MEM_LAT); cpu_rdata=32'hC0DE0100. Then read 0x0010 -> miss; cpu_rdata=32'h12345678 (writeback verified).
- Pulse cpu_req during a miss in progress -> ignored; exactly one cpu_ready pulse.
- Assert rst during REFILL -> cpu_ready stays 0. A subsequent read of the same address misses and returns the memory value.
